instruction_sender: RTL and testbench
=====================================

INSTRUCTION_SENDER -- requirements
Module: instruction_sender

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 2, meaning instruction bytes per transfer (1..8).
REQ-002 SHALL have parameter SETUP_CYCLES, default 1, meaning data-stable cycles before strobe rises (>=1).
REQ-003 SHALL have parameter STROBE_CYCLES, default 2, meaning cycles o_capturebyte is held high (>=1).
REQ-004 SHALL have parameter HOLD_CYCLES, default 1, meaning data-stable cycles after strobe falls (>=1).
REQ-005 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port i_instruction, input, 8*NUM_BYTES, instruction word; byte 0 = bits [7:0].
REQ-008 SHALL have port i_valid, input, 1, i_instruction is offered.
REQ-009 SHALL have port o_ready, output, 1, sender can accept a word.
REQ-010 SHALL have port o_data, output, 8, byte presented to the instruction latch data input.
REQ-011 SHALL have port o_capturebyte, output, 1, latch-enable strobe to the instruction latch.
REQ-012 SHALL have port o_done, output, 1, one-cycle pulse when the last byte's HOLD completes.

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, STROBE, HOLD, DONE.
REQ-014 SHALL assert o_ready only in IDLE; accept on i_valid && o_ready, registering i_instruction and going to SETUP with byte index 0.
REQ-015 SHALL ignore i_valid and i_instruction changes outside IDLE.
REQ-016 SHALL drive o_data from a register equal to the current byte (index 0 first) throughout SETUP, STROBE and HOLD.
REQ-017 SHALL hold o_capturebyte high exactly STROBE_CYCLES consecutive cycles in STROBE, low in every other state, glitch-free (registered).
REQ-018 SHALL spend exactly SETUP_CYCLES in SETUP and HOLD_CYCLES in HOLD, counted by a down-counter reloaded on each state entry.
REQ-019 SHALL, at HOLD end, go to SETUP with index+1 and the next byte if index < NUM_BYTES-1, else to DONE.
REQ-020 SHALL pulse o_done in DONE for exactly one cycle, then return to IDLE (o_ready high the following cycle).
REQ-021 SHALL therefore take NUM_BYTES*(SETUP+STROBE+HOLD)+1 cycles from acceptance to o_done; earliest next acceptance one cycle after o_done.
REQ-022 SHALL size the byte index as clog2(NUM_BYTES+1) bits, never wrapping past the last byte.

Reset
REQ-023 SHALL on i_reset, synchronously, set IDLE, o_ready=1 the next cycle, o_data=8'h00, o_capturebyte=0, o_done=0, counters/index zero.
REQ-024 SHALL abort any transfer when i_reset is asserted mid-operation, dropping o_capturebyte low on the next edge; no o_done.
REQ-025 SHALL give i_reset priority over a simultaneous i_valid handshake.

Configuration
REQ-026 SHALL, with INSTRUCTION_SENDER_PARITY_EN defined, append one extra transfer after the last byte whose value is the XOR of all NUM_BYTES bytes, with identical SETUP/STROBE/HOLD timing; o_done follows the parity byte.
REQ-027 SHALL, without INSTRUCTION_SENDER_PARITY_EN, send exactly NUM_BYTES bytes and contain no parity logic.

Structure
REQ-028 SHALL place the state enum typedef and default timing constants in package instruction_sender_pkg.
REQ-029 SHALL use one sub-module, instruction_sender_timer: loadable down-counter with terminal-count output, shared by SETUP/STROBE/HOLD.

Verification
REQ-030 SHALL cover: defaults, i_instruction=16'hA55A, i_valid one cycle -> o_data 8'h5A then 8'hA5, o_capturebyte high 2 cycles per byte, o_done 9 cycles after acceptance.
REQ-031 SHALL cover: i_valid held high continuously with 16'h1234 then 16'hBEEF -> second word accepted only in IDLE after o_done; bytes 34,12,EF,BE in order.
REQ-032 SHALL cover: i_reset asserted during second byte's STROBE -> o_capturebyte low next cycle, o_data=8'h00, no o_done, o_ready high after reset release.
REQ-033 SHALL cover: i_instruction changed to 16'hFFFF during transfer of 16'h0F0F -> outputs still 8'h0F, 8'h0F.
REQ-034 SHALL cover: INSTRUCTION_SENDER_PARITY_EN defined, 16'hA55A -> third byte 8'hFF strobed, o_done 13 cycles after acceptance.
REQ-035 SHALL cover: bench model of a transparent latch captures on o_capturebyte falling edge; assert captured byte equals expected each transfer and o_data never changes while o_capturebyte high.

Source files
------------

// File: rtl/instruction_sender_pkg.sv
// instruction_sender_pkg: FSM state type, default timing constants and counter sizing helper.
package instruction_sender_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    localparam int DEF_NUM_BYTES     = 2;
    localparam int DEF_SETUP_CYCLES  = 1;
    localparam int DEF_STROBE_CYCLES = 2;
    localparam int DEF_HOLD_CYCLES   = 1;

    function automatic int count_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/instruction_sender_timer.sv
// instruction_sender_timer: loadable down-counter; tc is high while the count is zero.
module instruction_sender_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else if (load) count <= value;
        else if (count != '0) count <= count - 1'b1;
    end

    assign tc = (count == '0);

endmodule

// File: rtl/instruction_sender.sv
// instruction_sender: streams an instruction word byte-by-byte to a latch with setup/strobe/hold timing.
// Optional INSTRUCTION_SENDER_PARITY_EN appends an XOR parity byte after the last instruction byte.
module instruction_sender
    import instruction_sender_pkg::*;
#(
    parameter int NUM_BYTES     = DEF_NUM_BYTES,
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [8*NUM_BYTES-1:0] i_instruction,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [7:0]             o_data,
    output logic                   o_capturebyte,
    output logic                   o_done
);

    localparam int TW = count_width(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
    localparam int IW = $clog2(NUM_BYTES + 1);

`ifdef INSTRUCTION_SENDER_PARITY_EN
    localparam int TOTAL = NUM_BYTES + 1;
    logic [7:0] parity;
    always_comb begin
        parity = '0;
        for (int i = 0; i < NUM_BYTES; i++) parity = parity ^ i_instruction[8*i +: 8];
    end
    logic [8*TOTAL-1:0] load_word;
    assign load_word = {parity, i_instruction};
`else
    localparam int TOTAL = NUM_BYTES;
    logic [8*TOTAL-1:0] load_word;
    assign load_word = i_instruction;
`endif

    state_t             state, next;
    logic [IW-1:0]      idx;
    logic [8*TOTAL-1:0] sreg;
    logic               load, tc, last;
    logic [TW-1:0]      load_val;

    instruction_sender_timer #(.W(TW)) u_timer (
        .clk   (i_clk),
        .rst   (i_reset),
        .load  (load),
        .value (load_val),
        .tc    (tc)
    );

    assign last   = (idx == IW'(TOTAL - 1));
    assign o_data = sreg[7:0];

    // Timer is reloaded with (cycles-1) on every state entry so tc marks the final cycle.
    always_comb begin
        next     = state;
        load     = 1'b0;
        load_val = '0;
        case (state)
            IDLE:   if (i_valid) begin next = SETUP; load = 1'b1; load_val = TW'(SETUP_CYCLES - 1); end
            SETUP:  if (tc) begin next = STROBE; load = 1'b1; load_val = TW'(STROBE_CYCLES - 1); end
            STROBE: if (tc) begin next = HOLD; load = 1'b1; load_val = TW'(HOLD_CYCLES - 1); end
            HOLD:   if (tc) begin
                next     = last ? DONE : SETUP;
                load     = 1'b1;
                load_val = last ? '0 : TW'(SETUP_CYCLES - 1);
            end
            DONE:   next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= IDLE;
            o_ready       <= 1'b1;
            o_capturebyte <= 1'b0;
            o_done        <= 1'b0;
            idx           <= '0;
            sreg          <= '0;
        end else begin
            state         <= next;
            o_ready       <= (next == IDLE);
            o_capturebyte <= (next == STROBE);
            o_done        <= (next == DONE);
            if (state == IDLE && i_valid) begin
                sreg <= load_word;
                idx  <= '0;
            end else if (state == HOLD && tc && !last) begin
                sreg <= sreg >> 8;
                idx  <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_sender.sv
// tb_instruction_sender: directed and random transfers checked against a latch-capture model.
module tb_instruction_sender;

    localparam int NB  = 2;
    localparam int SC  = 1;
    localparam int STC = 2;
    localparam int HC  = 1;
`ifdef INSTRUCTION_SENDER_PARITY_EN
    localparam int NX = NB + 1;
`else
    localparam int NX = NB;
`endif

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b1;
    logic            i_valid = 1'b0;
    logic [8*NB-1:0] i_instruction = '0;
    logic            o_ready, o_capturebyte, o_done;
    logic [7:0]      o_data;

    instruction_sender #(
        .NUM_BYTES(NB), .SETUP_CYCLES(SC), .STROBE_CYCLES(STC), .HOLD_CYCLES(HC)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_instruction (i_instruction),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .o_data        (o_data),
        .o_capturebyte (o_capturebyte),
        .o_done        (o_done)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int         n_cmp = 0;
    int         n_err = 0;
    int         acc_q[$];
    logic [7:0] cap_q[$];
    int         len_q[$];
    logic       prev_cap = 1'b0;
    logic [7:0] prev_data = '0;
    logic [7:0] latch = '0;
    int         run = 0;

    // Transparent latch model: follows o_data while strobed, holds it when the strobe falls.
    always @(negedge i_clk) begin
        if (i_valid && o_ready && !i_reset) acc_q.push_back(cyc);
        if (o_capturebyte) begin
            latch = o_data;
            run++;
            if (prev_cap) begin
                n_cmp++;
                assert (o_data === prev_data) else begin
                    n_err++;
                    $error("FAIL data_stable_strobe: observed %02h expected %02h", o_data, prev_data);
                end
            end
        end else if (prev_cap) begin
            cap_q.push_back(latch);
            len_q.push_back(run);
            run = 0;
        end
        prev_cap  = o_capturebyte;
        prev_data = o_data;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_byte(input logic [8*NB-1:0] w, input int i);
        int p;
        if (i < NB) return int'((w >> (8 * i)) & 'hFF);
        p = 0;
        for (int j = 0; j < NB; j++) p = p ^ int'((w >> (8 * j)) & 'hFF);
        return p;
    endfunction

    task automatic wait_done(output int dc);
        for (int k = 0; k < 400; k++) begin
            @(negedge i_clk);
            if (o_done) begin
                dc = cyc;
                return;
            end
        end
        dc = -1;
        chk("done_timeout", 0, 1);
    endtask

    task automatic verify(input logic [8*NB-1:0] w, input int ai, input int dc);
        if (ai < acc_q.size()) chk("latency", dc - acc_q[ai], NX * (SC + STC + HC) + 1);
        else chk("accept_seen", acc_q.size(), ai + 1);
        chk("byte_count", cap_q.size(), NX);
        for (int i = 0; i < cap_q.size() && i < NX; i++) chk("captured_byte", int'(cap_q[i]), exp_byte(w, i));
        foreach (len_q[i]) chk("strobe_len", len_q[i], STC);
        cap_q.delete();
        len_q.delete();
    endtask

    task automatic xfer(input logic [8*NB-1:0] w, input bit junk);
        int ai, dc;
        ai = acc_q.size();
        @(posedge i_clk); #1;
        i_instruction = w;
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        if (junk) begin
            i_instruction = '1;
            i_valid = 1'b1;
            repeat (3) @(posedge i_clk);
            #1 i_valid = 1'b0;
        end
        wait_done(dc);
        chk("accept_count", acc_q.size() - ai, 1);
        verify(w, ai, dc);
        @(negedge i_clk);
        chk("ready_after_done", int'(o_ready), 1);
        chk("done_one_cycle", int'(o_done), 0);
    endtask

    initial begin
        int ai, d1, d2, seen;
        bit hit;
        logic [8*NB-1:0] w;

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_ready", int'(o_ready), 1);
        chk("reset_data", int'(o_data), 0);
        chk("reset_capture", int'(o_capturebyte), 0);
        chk("reset_done", int'(o_done), 0);
        @(posedge i_clk); #1 i_reset = 1'b0;

        xfer(16'hA55A, 1'b0);

        // valid held high across two words
        ai = acc_q.size();
        @(posedge i_clk); #1;
        i_instruction = 16'h1234;
        i_valid = 1'b1;
        @(posedge i_clk); #1 i_instruction = 16'hBEEF;
        wait_done(d1);
        verify(16'h1234, ai, d1);
        @(negedge i_clk);
        chk("b2b_ready", int'(o_ready), 1);
        @(posedge i_clk); #1 i_valid = 1'b0;
        wait_done(d2);
        if (ai + 1 < acc_q.size()) chk("b2b_gap", acc_q[ai + 1] - d1, 1);
        else chk("b2b_second_accept", acc_q.size(), ai + 2);
        verify(16'hBEEF, ai + 1, d2);
        chk("b2b_accepts", acc_q.size() - ai, 2);
        @(negedge i_clk);

        // reset during the second byte's strobe
        @(posedge i_clk); #1;
        i_instruction = 16'hC33C;
        i_valid = 1'b1;
        @(posedge i_clk); #1 i_valid = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            @(posedge i_clk); #1;
            if (o_capturebyte && cap_q.size() == 1) hit = 1'b1;
        end
        chk("strobe2_reached", int'(hit), 1);
        i_reset = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        chk("abort_capture", int'(o_capturebyte), 0);
        chk("abort_data", int'(o_data), 0);
        chk("abort_done", int'(o_done), 0);
        @(posedge i_clk); #1 i_reset = 1'b0;
        @(negedge i_clk);
        chk("abort_ready", int'(o_ready), 1);
        seen = 0;
        repeat (20) begin
            @(negedge i_clk);
            if (o_done) seen++;
        end
        chk("abort_no_done", seen, 0);
        if (cap_q.size() > 0) chk("abort_first_byte", int'(cap_q[0]), 'h3C);
        cap_q.delete();
        len_q.delete();

        xfer(16'h0F0F, 1'b1);

        repeat (6) begin
            w = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge i_clk);
            xfer(w, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
